// File: rtl/store_buffer_lsu.sv
// store_buffer_lsu: load/store unit with a FIFO store buffer, store-to-load forwarding
// and opportunistic draining of buffered stores when the memory port is idle.
module store_buffer_lsu #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] CpuAddress,
  input  logic [DATA_W-1:0] CpuWriteData,
  input  logic              CpuMemRead,
  input  logic              CpuMemWrite,
  output logic [DATA_W-1:0] CpuReadData,
  output logic              Stall,
  output logic              Empty,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ReadData
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head, tail, idx;
  logic [PW:0]       count;
  logic              fwd_hit_q, hit, is_ld, is_st, full, push, miss, fwd_hit, drain;
  logic [DATA_W-1:0] fwd_data_q, fwd_data;
  assign is_ld   = CpuMemRead;
  assign is_st   = !CpuMemRead && CpuMemWrite;
  assign full    = count == FULL_CNT;
  assign push    = is_st && !full;
  assign fwd_hit = is_ld && hit;
  assign miss    = is_ld && !hit;
  // the port is busy only for a load miss or an accepted store
  assign drain   = count != '0 && !miss && !push;
  assign Stall       = is_st && full;
  assign Empty       = count == '0;
  assign MemRead     = miss;
  assign MemWrite    = drain;
  assign Address     = miss ? CpuAddress : addr_q[head];
  assign WriteData   = data_q[head];
  assign CpuReadData = fwd_hit_q ? fwd_data_q : ReadData;
  // walk oldest to youngest so the youngest match wins
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + i[PW-1:0];
      if (valid_q[idx] && addr_q[idx] == CpuAddress) begin
        hit = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
  always_ff @(posedge Clock) begin
    if (push) begin
      addr_q[tail] <= CpuAddress;
      data_q[tail] <= CpuWriteData;
    end
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid_q    <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q <= fwd_hit;
      if (fwd_hit) fwd_data_q <= fwd_data;
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
        count         <= count + 1'b1;
      end else if (drain) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
        count         <= count - 1'b1;
      end
    end
  end
endmodule
